// File: rtl/slr_xing_arbiter.sv
// ============================================================================
// slr_xing_arbiter : credit-based round-robin arbiter feeding one SLR crossing
// Rev 1.0
// ============================================================================
`default_nettype none

module slr_xing_arbiter #(
   parameter  int N         = 4,
   parameter  int DATA_W    = 32,
   parameter  int CREDITS   = 6,
   parameter  int MAX_BURST = 4,
   localparam int TAG_W     = (N > 1) ? $clog2(N) : 1,
   localparam int CW        = $clog2(CREDITS + 1)
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic [N-1:0]        in_valid,
   output logic [N-1:0]        in_ready,
   input  logic [N*DATA_W-1:0] in_bits,
   output logic                out_valid,
   output logic [DATA_W-1:0]   out_bits,
   output logic [TAG_W-1:0]    out_tag,
   input  logic                credit_ret,
   output logic [CW-1:0]       credits_avail,
   output logic                err_credit_ovf
);

   localparam int             BW         = $clog2(MAX_BURST + 1);
   localparam logic [BW-1:0]  BURST_MAX  = BW'(MAX_BURST);
   localparam logic [CW-1:0]  CREDIT_MAX = CW'(CREDITS);
   localparam logic [TAG_W-1:0] OWNER_RST = TAG_W'(N - 1);

   logic [TAG_W-1:0]  r_owner;
   logic [BW-1:0]     r_beats;
   logic [CW-1:0]     r_credits;
   logic              r_err;
   logic              r_out_valid;
   logic [DATA_W-1:0] r_out_bits;
   logic [TAG_W-1:0]  r_out_tag;

   logic              w_hold;
   logic              w_grant_vld;
   logic [TAG_W-1:0]  w_grant;
   logic              w_fire;
   logic              w_continue;
   logic [DATA_W-1:0] w_data;

   assign w_hold = (r_beats != '0) && (r_beats < BURST_MAX) && in_valid[r_owner];

   // Scan from the farthest candidate down so the nearest one after owner wins.
   always_comb begin
      int idx;
      idx         = 0;
      w_grant_vld = 1'b0;
      w_grant     = r_owner;
      if (w_hold) begin
         w_grant_vld = 1'b1;
      end else begin
         for (int k = N; k >= 1; k--) begin
            idx = int'(r_owner) + k;
            if (idx >= N) begin
               idx = idx - N;
            end
            if (in_valid[idx]) begin
               w_grant_vld = 1'b1;
               w_grant     = idx[TAG_W-1:0];
            end
         end
      end
   end

   assign w_fire     = w_grant_vld && (r_credits != '0);
   assign w_continue = (w_grant == r_owner) && (r_beats != '0) && (r_beats < BURST_MAX);
   assign w_data     = in_bits[w_grant*DATA_W +: DATA_W];

   always_comb begin
      in_ready = '0;
      if (w_fire) begin
         in_ready[w_grant] = 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_owner <= OWNER_RST;
         r_beats <= '0;
      end else if (w_fire) begin
         if (w_continue) begin
            r_beats <= r_beats + BW'(1);
         end else begin
            r_owner <= w_grant;
            r_beats <= BW'(1);
         end
      end else if ((r_beats != '0) && !in_valid[r_owner]) begin
         r_beats <= '0;
      end
   end

   // A credit stall with the owner still valid keeps the hold intact.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_credits <= CREDIT_MAX;
         r_err     <= 1'b0;
      end else begin
         case ({w_fire, credit_ret})
            2'b10: r_credits <= r_credits - CW'(1);
            2'b01: begin
               if (r_credits == CREDIT_MAX) begin
                  r_err <= 1'b1;
               end else begin
                  r_credits <= r_credits + CW'(1);
               end
            end
            default: r_credits <= r_credits;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_out_valid <= 1'b0;
         r_out_bits  <= '0;
         r_out_tag   <= '0;
      end else begin
         r_out_valid <= w_fire;
         if (w_fire) begin
            r_out_bits <= w_data;
            r_out_tag  <= w_grant;
         end
      end
   end

   assign out_valid      = r_out_valid;
   assign out_bits       = r_out_bits;
   assign out_tag        = r_out_tag;
   assign credits_avail  = r_credits;
   assign err_credit_ovf = r_err;

endmodule

`default_nettype wire

// File: tb/tb_slr_xing_arbiter.sv
// ============================================================================
// tb_slr_xing_arbiter : directed table plus corner-case sequences
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_slr_xing_arbiter;

   localparam int N = 4;
   localparam int DW = 32;

   logic          clock = 1'b0;
   logic          reset_n;
   logic [N-1:0]  in_valid;
   logic [N-1:0]  in_ready;
   logic [N*DW-1:0] in_bits;
   logic          out_valid;
   logic [DW-1:0] out_bits;
   logic [1:0]    out_tag;
   logic          credit_ret;
   logic [2:0]    credits_avail;
   logic          err_credit_ovf;

   int checks = 0;
   int errors = 0;

   slr_xing_arbiter #(.N(4), .DATA_W(32), .CREDITS(6), .MAX_BURST(4)) dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_bits        (in_bits),
      .out_valid      (out_valid),
      .out_bits       (out_bits),
      .out_tag        (out_tag),
      .credit_ret     (credit_ret),
      .credits_avail  (credits_avail),
      .err_credit_ovf (err_credit_ovf)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic       rst;
      logic [3:0] valid;
      logic       ret;
      logic [3:0] ready;
      logic       ov;
      logic [1:0] tag;
      logic [2:0] cred;
      logic       err;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(logic rst, logic [3:0] valid, logic ret, logic [3:0] ready,
                               logic ov, logic [1:0] tag, logic [2:0] cred, logic err);
      vec_t v;
      v.rst = rst; v.valid = valid; v.ret = ret; v.ready = ready;
      v.ov = ov; v.tag = tag; v.cred = cred; v.err = err;
      return v;
   endfunction

   function automatic logic [31:0] pat(int v, int i);
      return {16'hC0DE, 8'(v), 8'(i)};
   endfunction

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset_n    = 1'b0;
      in_valid   = '0;
      credit_ret = 1'b0;
      repeat (2) tick();
      reset_n = 1'b1;
   endtask

   task automatic set_bits(int v);
      for (int i = 0; i < N; i++) in_bits[i*DW +: DW] = pat(v, i);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset_n = 1'b1; in_valid = '0; credit_ret = 1'b0; in_bits = '0;

      // Group A: round robin with continuous credit return
      tbl.push_back(mk(1, 4'hF, 1, 4'b0001, 1, 0, 6, 0));
      tbl.push_back(mk(0, 4'hF, 1, 4'b0001, 1, 0, 6, 0));
      tbl.push_back(mk(0, 4'hF, 1, 4'b0001, 1, 0, 6, 0));
      tbl.push_back(mk(0, 4'hF, 1, 4'b0001, 1, 0, 6, 0));
      tbl.push_back(mk(0, 4'hF, 1, 4'b0010, 1, 1, 6, 0));
      tbl.push_back(mk(0, 4'hF, 1, 4'b0010, 1, 1, 6, 0));
      tbl.push_back(mk(0, 4'hF, 1, 4'b0010, 1, 1, 6, 0));
      tbl.push_back(mk(0, 4'hF, 1, 4'b0010, 1, 1, 6, 0));
      tbl.push_back(mk(0, 4'hF, 1, 4'b0100, 1, 2, 6, 0));
      // Group B: single requester, no bubble at burst boundary
      for (int k = 0; k < 6; k++)
         tbl.push_back(mk(k == 0, 4'b0001, 1, 4'b0001, 1, 0, 6, 0));
      // Group C: credit overflow is sticky
      tbl.push_back(mk(1, 4'b0000, 1, 4'b0000, 0, 0, 6, 1));
      tbl.push_back(mk(0, 4'b0000, 0, 4'b0000, 0, 0, 6, 1));
      tbl.push_back(mk(0, 4'b0010, 0, 4'b0010, 1, 1, 5, 1));
      tbl.push_back(mk(0, 4'b0000, 1, 4'b0000, 0, 1, 6, 1));

      do_reset();
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_bits", 64'(out_bits), 64'd0);
      chk("rst_out_tag", 64'(out_tag), 64'd0);
      chk("rst_credits", 64'(credits_avail), 64'd6);
      chk("rst_err", 64'(err_credit_ovf), 64'd0);

      foreach (tbl[v]) begin
         if (tbl[v].rst) do_reset();
         in_valid   = tbl[v].valid;
         credit_ret = tbl[v].ret;
         set_bits(v);
         #1;
         chk($sformatf("tbl%0d_ready", v), 64'(in_ready), 64'(tbl[v].ready));
         tick();
         chk($sformatf("tbl%0d_ov", v), 64'(out_valid), 64'(tbl[v].ov));
         chk($sformatf("tbl%0d_tag", v), 64'(out_tag), 64'(tbl[v].tag));
         chk($sformatf("tbl%0d_cred", v), 64'(credits_avail), 64'(tbl[v].cred));
         chk($sformatf("tbl%0d_err", v), 64'(err_credit_ovf), 64'(tbl[v].err));
         if (tbl[v].ov) chk($sformatf("tbl%0d_bits", v), 64'(out_bits), 64'(pat(v, int'(tbl[v].tag))));
      end

      // Credit exhaustion on requester 2, then one credit releases 0xA6
      do_reset();
      set_bits(200);
      in_valid = 4'b0100;
      for (int c = 0; c < 6; c++) begin
         in_bits[2*DW +: DW] = 32'hA0 + 32'(c);
         #1;
         chk($sformatf("exh%0d_ready", c), 64'(in_ready), 64'b0100);
         tick();
         chk($sformatf("exh%0d_bits", c), 64'(out_bits), 64'(32'hA0 + 32'(c)));
         chk($sformatf("exh%0d_tag", c), 64'(out_tag), 64'd2);
      end
      in_bits[2*DW +: DW] = 32'hA6;
      #1;
      chk("exh_stall_ready", 64'(in_ready), 64'd0);
      chk("exh_stall_cred", 64'(credits_avail), 64'd0);
      credit_ret = 1'b1;
      #1;
      chk("exh_ret_ready", 64'(in_ready), 64'd0);
      tick();
      credit_ret = 1'b0;
      chk("exh_ret_ov", 64'(out_valid), 64'd0);
      chk("exh_ret_cred", 64'(credits_avail), 64'd1);
      #1;
      chk("exh_a6_ready", 64'(in_ready), 64'b0100);
      tick();
      chk("exh_a6_ov", 64'(out_valid), 64'd1);
      chk("exh_a6_bits", 64'(out_bits), 64'hA6);
      chk("exh_a6_cred", 64'(credits_avail), 64'd0);

      // Hold released when owner drops valid mid-burst
      do_reset();
      set_bits(201);
      credit_ret = 1'b1;
      begin
         logic [3:0] hv [7];
         logic [1:0] ht [7];
         hv = '{4'b0010, 4'b0010, 4'b1000, 4'b1010, 4'b1010, 4'b1010, 4'b1010};
         ht = '{2'd1, 2'd1, 2'd3, 2'd3, 2'd3, 2'd3, 2'd1};
         for (int c = 0; c < 7; c++) begin
            in_valid = hv[c];
            #1;
            chk($sformatf("hold%0d_ready", c), 64'(in_ready), 64'(4'b0001 << ht[c]));
            tick();
            chk($sformatf("hold%0d_tag", c), 64'(out_tag), 64'(ht[c]));
         end
      end
      credit_ret = 1'b0;

      // Fire and credit return together at credits = 3
      do_reset();
      in_valid = 4'b0001;
      repeat (3) tick();
      chk("both_pre_cred", 64'(credits_avail), 64'd3);
      credit_ret = 1'b1;
      tick();
      chk("both_cred", 64'(credits_avail), 64'd3);
      chk("both_ov", 64'(out_valid), 64'd1);
      credit_ret = 1'b0;
      in_valid   = 4'b0000;
      tick();
      chk("both_idle_cred", 64'(credits_avail), 64'd3);

      // Asynchronous reset mid-stream
      do_reset();
      set_bits(202);
      credit_ret = 1'b1;
      tick();
      in_valid = 4'b1110;
      repeat (3) tick();
      chk("arst_pre_err", 64'(err_credit_ovf), 64'd1);
      chk("arst_pre_tag", 64'(out_tag), 64'd1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("arst_ov", 64'(out_valid), 64'd0);
      chk("arst_bits", 64'(out_bits), 64'd0);
      chk("arst_tag", 64'(out_tag), 64'd0);
      chk("arst_cred", 64'(credits_avail), 64'd6);
      chk("arst_err", 64'(err_credit_ovf), 64'd0);
      credit_ret = 1'b0;
      tick();
      reset_n  = 1'b1;
      in_valid = 4'b1100;
      #1;
      chk("arst_first_ready", 64'(in_ready), 64'b0100);
      tick();
      chk("arst_first_tag", 64'(out_tag), 64'd2);
      chk("arst_first_bits", 64'(out_bits), 64'(pat(202, 2)));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/slr_xing_arbiter.md
# slr_xing_arbiter

Credit-based round-robin arbiter that shares one inter-SLR crossing channel between N requesters. It sits on the sending side of an SLR boundary and feeds the 32-bit crossing FIFO. Downstream ready is replaced by a credit loop, so no combinational path crosses the SLR. The output is registered and tagged with the source index so the far side can demultiplex.

## Interface
Parameters:
- N, default 4: number of requesters, 2..16.
- DATA_W, default 32: payload width.
- CREDITS, default 6: initial and maximum credits; equals the far-side FIFO slack.
- MAX_BURST, default 4: maximum consecutive beats one requester may hold the grant, 1..15.
- TAG_W = max(1, $clog2(N)); CW = $clog2(CREDITS+1) (derived).

Ports:
- clock  in  1: sole clock, rising edge.
- reset_n  in  1: asynchronous, active-low reset.
- in_valid  in  N: per-requester valid.
- in_ready  out  N: per-requester ready; combinational, at most one bit set.
- in_bits  in  N*DATA_W: requester i occupies bits [i*DATA_W +: DATA_W].
- out_valid  out  1: registered; one beat per asserted cycle, no backpressure.
- out_bits  out  DATA_W: registered payload.
- out_tag  out  TAG_W: registered source index.
- credit_ret  in  1: one-cycle pulse per entry freed on the far side.
- credits_avail  out  CW: current credit count.
- err_credit_ovf  out  1: sticky; set when a credit is returned while the counter is already at CREDITS.

## Operation
- State registers: owner (TAG_W bits), beats (0..MAX_BURST), credits (CW bits), err_credit_ovf.
- Grant g is combinational:
  - If beats != 0, beats < MAX_BURST and in_valid[owner], then g = owner.
  - Otherwise g is the first set in_valid in the order owner+1, owner+2, …, wrapping modulo N, ending at owner.
  - If no in_valid bit is set, there is no grant.
- in_ready[g] = 1 only when a grant exists and credits != 0. All other in_ready bits are 0. in_ready is never a function of credit_ret in the same cycle.
- fire = in_valid[g] & in_ready[g].
- Update on fire:
  - If g == owner, beats != 0 and beats < MAX_BURST: beats <= beats+1.
  - Otherwise: owner <= g, beats <= 1.
- Without fire:
  - If beats != 0 and !in_valid[owner]: beats <= 0 (hold released).
  - Otherwise owner and beats are unchanged. A zero-credit stall does not release the hold.
- When beats == MAX_BURST, the search starts at owner+1. The owner is re-granted (with beats <= 1) only if no other requester is valid.
- Credit counter:
  - fire only: credits-1.
  - credit_ret only: credits+1, saturating at CREDITS; if already at CREDITS, set err_credit_ovf.
  - fire and credit_ret together: unchanged.
- Output register:
  - On fire: out_valid <= 1, out_bits <= in_bits[g], out_tag <= g.
  - Otherwise: out_valid <= 0, and out_bits/out_tag hold their previous values.

## Timing
- Reset values (asynchronous, while reset_n = 0):
  - out_valid = 0, out_bits = 0, out_tag = 0, err_credit_ovf = 0.
  - credits = credits_avail = CREDITS.
  - owner = N-1, so the first search starts at requester 0.
  - beats = 0.
- Reset asserted mid-burst drops any beat not yet registered. Nothing already sent on out_* is replayed.
- Latency: an accepted beat appears on out_* on the cycle after the fire edge. Throughput is 1 beat/cycle while credits > 0.
- A credit returned in cycle t is usable for a fire in cycle t+1.
- credits_avail reflects the registered count: it decrements the cycle after fire and increments the cycle after credit_ret.
- A requester must hold in_valid and in_bits stable until in_ready. The arbiter never grants a requester whose in_valid is 0.

## Test plan
- Reset, all 4 requesters valid continuously, credit_ret pulsed every cycle, MAX_BURST=4:
  - out_tag sequence is 0,0,0,0,1,1,1,1,2,…; out_valid is high every cycle after the first fire.
  - credits_avail stays at 6 during steady state.
- No credit_ret, requester 2 valid with 10 beats 0xA0..0xA9:
  - Exactly 6 beats go out (0xA0..0xA5, tag 2); then in_ready = 0 and credits_avail = 0.
  - One credit_ret pulse: 0xA6 fires on the next cycle.
- Requester 1 holds the grant with beats = 2; in_valid[1] drops for one cycle while requester 3 is valid:
  - Requester 3 is granted next; requester 1 returns only after the round-robin pointer wraps.
- Only requester 0 valid, MAX_BURST = 4, ample credits:
  - Continuous back-to-back tag-0 beats, no bubble at the burst boundary (beats restarts at 1).
- credit_ret pulsed at credits = 6 with no fire: credits_avail stays 6 and err_credit_ovf becomes 1 and stays 1 until reset.
- Fire and credit_ret in the same cycle at credits = 3: credits_avail stays 3.
- reset_n asserted mid-stream: all outputs go to their reset values immediately, without waiting for a clock edge.
  - After release, the first grant goes to the lowest-index valid requester.
